adder_pipe: RTL and testbench

- Parametrised, carry-segmented, pipelined adder/subtractor.
- Next generation of the team's 4-bit combinational adder: generic width, add/sub mode, signed overflow flag and valid/ready flow control.
- The carry chain is split into SEG-bit segments, one pipeline stage per segment, so wide operands close timing at full clock rate.
- Sits between an operand source and a result consumer, both using valid/ready handshakes.

---
 rtl/adder_pipe_if.sv | 26 ++
 rtl/adder_pipe.sv | 97 +++++++++
 tb/tb_adder_pipe.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/adder_pipe_if.sv
// Operand and result valid/ready channels of the pipelined adder/subtractor.
// The producer/consumer side takes the master modport and the adder takes the slave modport.
interface adder_pipe_if #(
   parameter int WIDTH = 16
);
   logic             inValid;
   logic             inReady;
   logic             sub;
   logic [WIDTH-1:0] dataA;
   logic [WIDTH-1:0] dataB;
   logic             outValid;
   logic             outReady;
   logic [WIDTH-1:0] sum;
   logic             carry;
   logic             overflow;

   modport master (
      output inValid, sub, dataA, dataB, outReady,
      input  inReady, outValid, sum, carry, overflow
   );

   modport slave (
      input  inValid, sub, dataA, dataB, outReady,
      output inReady, outValid, sum, carry, overflow
   );
endinterface

// File: rtl/adder_pipe.sv
// Carry-segmented pipelined adder/subtractor: one SEG-bit slice of the carry chain per stage,
// with a single global stall so every stage shifts or holds together.
module adder_pipe #(
   parameter int WIDTH = 16,
   parameter int SEG   = 4
) (
   input logic         clk,
   input logic         rst,
   adder_pipe_if.slave bus
);
   localparam int NSEG = WIDTH / SEG;

   if (WIDTH % SEG != 0) begin : gBadParams
      $error("adder_pipe: WIDTH (%0d) must be a multiple of SEG (%0d)", WIDTH, SEG);
   end

   logic             advance;
   logic [WIDTH-1:0] bIn;

   // Stage k registers; partial sum holds bits below (k+1)*SEG, operands ride along for later slices.
   logic             vld  [NSEG];
   logic [WIDTH-1:0] pSum [NSEG];
   logic             cry  [NSEG];
   logic [WIDTH-1:0] opA  [NSEG];
   logic [WIDTH-1:0] opB  [NSEG];
   logic             ovfReg;

   logic             prevVld [NSEG];
   logic [WIDTH-1:0] prevSum [NSEG];
   logic             prevCin [NSEG];
   logic [WIDTH-1:0] prevA   [NSEG];
   logic [WIDTH-1:0] prevB   [NSEG];
   logic [WIDTH-1:0] nextSum [NSEG];
   logic             segCout [NSEG];
   logic             nextOvf;

   assign bIn          = bus.sub ? ~bus.dataB : bus.dataB;
   assign advance      = !vld[NSEG-1] || bus.outReady;
   assign bus.inReady  = advance;
   assign bus.outValid = vld[NSEG-1];
   assign bus.sum      = pSum[NSEG-1];
   assign bus.carry    = cry[NSEG-1];
   assign bus.overflow = ovfReg;

   // Stage 0 feeds from the port (the subtract +1 enters as its carry-in); later stages feed from their predecessor.
   always_comb begin
      prevVld[0] = bus.inValid;
      prevSum[0] = '0;
      prevCin[0] = bus.sub;
      prevA[0]   = bus.dataA;
      prevB[0]   = bIn;
      for (int k = 1; k < NSEG; k++) begin
         prevVld[k] = vld[k-1];
         prevSum[k] = pSum[k-1];
         prevCin[k] = cry[k-1];
         prevA[k]   = opA[k-1];
         prevB[k]   = opB[k-1];
      end
   end

   always_comb begin
      logic [SEG:0] segRes;
      segRes  = '0;
      nextOvf = 1'b0;
      for (int k = 0; k < NSEG; k++) begin
         segRes = {1'b0, prevA[k][k*SEG +: SEG]} + {1'b0, prevB[k][k*SEG +: SEG]}
                + {{SEG{1'b0}}, prevCin[k]};
         nextSum[k]                = prevSum[k];
         nextSum[k][k*SEG +: SEG]  = segRes[SEG-1:0];
         segCout[k]                = segRes[SEG];
      end
      nextOvf = (prevA[NSEG-1][WIDTH-1] == prevB[NSEG-1][WIDTH-1])
             && (nextSum[NSEG-1][WIDTH-1] != prevA[NSEG-1][WIDTH-1]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NSEG; k++) begin
            vld[k]  <= 1'b0;
            pSum[k] <= '0;
            cry[k]  <= 1'b0;
            opA[k]  <= '0;
            opB[k]  <= '0;
         end
         ovfReg <= 1'b0;
      end else if (advance) begin
         for (int k = 0; k < NSEG; k++) begin
            vld[k]  <= prevVld[k];
            pSum[k] <= nextSum[k];
            cry[k]  <= segCout[k];
            opA[k]  <= prevA[k];
            opB[k]  <= prevB[k];
         end
         ovfReg <= nextOvf;
      end
   end
endmodule

// File: tb/tb_adder_pipe.sv
// Directed bench for adder_pipe: a 16/4 instance for the main scenarios plus 4/4 and 8/2 corner instances.
module tb_adder_pipe;
   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   adder_pipe_if #(.WIDTH(16)) bus16 ();
   adder_pipe_if #(.WIDTH(4))  bus4 ();
   adder_pipe_if #(.WIDTH(8))  bus8 ();

   adder_pipe #(.WIDTH(16), .SEG(4)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
   adder_pipe #(.WIDTH(4),  .SEG(4)) dut4  (.clk(clk), .rst(rst), .bus(bus4));
   adder_pipe #(.WIDTH(8),  .SEG(2)) dut8  (.clk(clk), .rst(rst), .bus(bus8));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus16.inValid = 1'b1; bus16.dataA = 16'h1234; bus16.dataB = 16'h0001; bus16.sub = 1'b0;
      bus16.outReady = 1'b1;
      step();
      step();
      checks++; if (bus16.outValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_outValid got %b want 0", bus16.outValid); end
      checks++; if (bus16.sum !== 16'h0000) begin failures++; $display("[TB] FAIL reset_sum got %h want 0000", bus16.sum); end
      checks++; if (bus16.carry !== 1'b0) begin failures++; $display("[TB] FAIL reset_carry got %b want 0", bus16.carry); end
      checks++; if (bus16.overflow !== 1'b0) begin failures++; $display("[TB] FAIL reset_overflow got %b want 0", bus16.overflow); end
      checks++; if (bus16.inReady !== 1'b1) begin failures++; $display("[TB] FAIL reset_inReady got %b want 1", bus16.inReady); end
      checks++; if (bus4.outValid !== 1'b0 || bus8.outValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_small_outValid got %b/%b want 0/0", bus4.outValid, bus8.outValid); end
      rst = 1'b0;
      bus16.inValid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         step();
         checks++; if (bus16.outValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_beat_taken cycle %0d got %b want 0", c, bus16.outValid); end
      end
   endtask

   task automatic test_directed();
      logic [15:0] va [4];
      logic [15:0] vb [4];
      logic        vs [4];
      logic [15:0] es [4];
      logic        ec [4];
      logic        eo [4];
      va = '{16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
      vb = '{16'h0001, 16'h0001, 16'h0007, 16'h0001};
      vs = '{1'b0, 1'b0, 1'b1, 1'b1};
      es = '{16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF};
      ec = '{1'b1, 1'b0, 1'b0, 1'b1};
      eo = '{1'b0, 1'b1, 1'b0, 1'b1};
      bus16.outReady = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus16.inValid = 1'b1; bus16.dataA = va[i]; bus16.dataB = vb[i]; bus16.sub = vs[i];
         step();
         bus16.inValid = 1'b0;
         for (int c = 1; c <= 3; c++) begin
            checks++; if (bus16.outValid !== 1'b0) begin failures++; $display("[TB] FAIL dir%0d_early cycle %0d got %b want 0", i, c, bus16.outValid); end
            step();
         end
         checks++; if (bus16.outValid !== 1'b1) begin failures++; $display("[TB] FAIL dir%0d_valid got %b want 1", i, bus16.outValid); end
         checks++; if (bus16.sum !== es[i]) begin failures++; $display("[TB] FAIL dir%0d_sum got %h want %h", i, bus16.sum, es[i]); end
         checks++; if (bus16.carry !== ec[i]) begin failures++; $display("[TB] FAIL dir%0d_carry got %b want %b", i, bus16.carry, ec[i]); end
         checks++; if (bus16.overflow !== eo[i]) begin failures++; $display("[TB] FAIL dir%0d_overflow got %b want %b", i, bus16.overflow, eo[i]); end
         step();
         checks++; if (bus16.outValid !== 1'b0) begin failures++; $display("[TB] FAIL dir%0d_one_cycle got %b want 0", i, bus16.outValid); end
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] va [8];
      logic [15:0] vb [8];
      logic        vs [8];
      logic [15:0] es [8];
      logic        ec [8];
      logic        eo [8];
      int          sent;
      int          got;
      logic        holdActive;
      logic [15:0] holdSum;
      logic        holdC;
      logic        holdO;
      logic        expReady;
      va = '{16'h1234, 16'hFFFF, 16'h8000, 16'h0000, 16'h7FFF, 16'hABCD, 16'h0F0F, 16'h4000};
      vb = '{16'h1111, 16'hFFFF, 16'h8000, 16'h0001, 16'hFFFF, 16'hABCD, 16'hF0F0, 16'h4000};
      vs = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      es = '{16'h2345, 16'hFFFE, 16'h0000, 16'hFFFF, 16'h8000, 16'h0000, 16'hFFFF, 16'h8000};
      ec = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      eo = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      sent = 0; got = 0; holdActive = 1'b0; holdSum = '0; holdC = 1'b0; holdO = 1'b0;
      // Pipeline is full from cycle 4, so the three-cycle stall starting at 5 must close inReady.
      for (int c = 0; c < 40 && got < 8; c++) begin
         bus16.outReady = !(c >= 5 && c < 8);
         expReady       = !(c >= 5 && c < 8);
         bus16.inValid  = (sent < 8);
         if (sent < 8) begin
            bus16.dataA = va[sent]; bus16.dataB = vb[sent]; bus16.sub = vs[sent];
         end
         #1;
         if (holdActive) begin
            checks++;
            if (bus16.outValid !== 1'b1 || bus16.sum !== holdSum || bus16.carry !== holdC || bus16.overflow !== holdO) begin
               failures++;
               $display("[TB] FAIL b2b_stall_stable cycle %0d got v=%b s=%h c=%b o=%b want v=1 s=%h c=%b o=%b",
                        c, bus16.outValid, bus16.sum, bus16.carry, bus16.overflow, holdSum, holdC, holdO);
            end
         end
         checks++; if (bus16.inReady !== expReady) begin failures++; $display("[TB] FAIL b2b_inReady cycle %0d got %b want %b", c, bus16.inReady, expReady); end
         if (bus16.outValid === 1'b1 && bus16.outReady === 1'b1) begin
            if (got < 8) begin
               checks++;
               if (bus16.sum !== es[got] || bus16.carry !== ec[got] || bus16.overflow !== eo[got]) begin
                  failures++;
                  $display("[TB] FAIL b2b_result%0d got s=%h c=%b o=%b want s=%h c=%b o=%b",
                           got, bus16.sum, bus16.carry, bus16.overflow, es[got], ec[got], eo[got]);
               end
            end
            got++;
         end
         holdActive = (bus16.outValid === 1'b1) && !bus16.outReady;
         holdSum = bus16.sum; holdC = bus16.carry; holdO = bus16.overflow;
         if (bus16.inValid && bus16.inReady === 1'b1) sent++;
         step();
      end
      bus16.inValid = 1'b0;
      bus16.outReady = 1'b1;
      checks++; if (got != 8) begin failures++; $display("[TB] FAIL b2b_count got %0d want 8", got); end
      for (int c = 0; c < 4; c++) begin
         checks++; if (bus16.outValid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_extra cycle %0d got %b want 0", c, bus16.outValid); end
         step();
      end
   endtask

   task automatic test_reset_flight();
      logic [15:0] va [3];
      logic [15:0] vb [3];
      va = '{16'hFFFF, 16'h8000, 16'h1234};
      vb = '{16'hFFFF, 16'h8000, 16'h1111};
      bus16.outReady = 1'b1;
      bus16.sub = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus16.inValid = 1'b1; bus16.dataA = va[i]; bus16.dataB = vb[i];
         step();
      end
      bus16.inValid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++; if (bus16.outValid !== 1'b0) begin failures++; $display("[TB] FAIL flush_outValid got %b want 0", bus16.outValid); end
      checks++; if (bus16.sum !== 16'h0000) begin failures++; $display("[TB] FAIL flush_sum got %h want 0000", bus16.sum); end
      checks++; if (bus16.carry !== 1'b0 || bus16.overflow !== 1'b0) begin failures++; $display("[TB] FAIL flush_flags got c=%b o=%b want 0/0", bus16.carry, bus16.overflow); end
      for (int c = 0; c < 6; c++) begin
         step();
         checks++; if (bus16.outValid !== 1'b0) begin failures++; $display("[TB] FAIL flush_ghost cycle %0d got %b want 0", c, bus16.outValid); end
      end
      bus16.inValid = 1'b1; bus16.dataA = 16'h0003; bus16.dataB = 16'h0004; bus16.sub = 1'b0;
      step();
      bus16.inValid = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         checks++; if (bus16.outValid !== 1'b0) begin failures++; $display("[TB] FAIL flush_new_early cycle %0d got %b want 0", c, bus16.outValid); end
         step();
      end
      checks++; if (bus16.outValid !== 1'b1 || bus16.sum !== 16'h0007) begin failures++; $display("[TB] FAIL flush_new_beat got v=%b s=%h want v=1 s=0007", bus16.outValid, bus16.sum); end
      step();
   endtask

   task automatic test_bubbles();
      logic expVld;
      bus16.outReady = 1'b1;
      bus16.sub = 1'b0;
      bus16.dataB = 16'h0100;
      for (int c = 0; c < 14; c++) begin
         bus16.inValid = (c < 8) && (c % 2 == 0);
         bus16.dataA = 16'(c + 1);
         #1;
         expVld = (c >= 4) && (c < 12) && ((c - 4) % 2 == 0);
         checks++; if (bus16.outValid !== expVld) begin failures++; $display("[TB] FAIL bubble_valid cycle %0d got %b want %b", c, bus16.outValid, expVld); end
         if (expVld) begin
            checks++; if (bus16.sum !== 16'(c - 3) + 16'h0100) begin failures++; $display("[TB] FAIL bubble_sum cycle %0d got %h want %h", c, bus16.sum, 16'(c - 3) + 16'h0100); end
         end
         step();
      end
      bus16.inValid = 1'b0;
   endtask

   task automatic test_single_stage();
      bus4.outReady = 1'b1;
      bus4.inValid = 1'b1; bus4.dataA = 4'hF; bus4.dataB = 4'h1; bus4.sub = 1'b0;
      step();
      bus4.inValid = 1'b0;
      checks++; if (bus4.outValid !== 1'b1) begin failures++; $display("[TB] FAIL w4_valid got %b want 1", bus4.outValid); end
      checks++; if (bus4.sum !== 4'h0 || bus4.carry !== 1'b1 || bus4.overflow !== 1'b0) begin failures++; $display("[TB] FAIL w4_result got s=%h c=%b o=%b want s=0 c=1 o=0", bus4.sum, bus4.carry, bus4.overflow); end
      step();
      checks++; if (bus4.outValid !== 1'b0) begin failures++; $display("[TB] FAIL w4_one_cycle got %b want 0", bus4.outValid); end
   endtask

   task automatic test_seg2();
      bus8.outReady = 1'b1;
      bus8.inValid = 1'b1; bus8.dataA = 8'hAA; bus8.dataB = 8'h56; bus8.sub = 1'b0;
      step();
      bus8.inValid = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         checks++; if (bus8.outValid !== 1'b0) begin failures++; $display("[TB] FAIL w8_early cycle %0d got %b want 0", c, bus8.outValid); end
         step();
      end
      checks++; if (bus8.outValid !== 1'b1) begin failures++; $display("[TB] FAIL w8_valid got %b want 1", bus8.outValid); end
      checks++; if (bus8.sum !== 8'h00 || bus8.carry !== 1'b1 || bus8.overflow !== 1'b0) begin failures++; $display("[TB] FAIL w8_result got s=%h c=%b o=%b want s=00 c=1 o=0", bus8.sum, bus8.carry, bus8.overflow); end
      step();
   endtask

   initial begin
      rst = 1'b1;
      bus16.inValid = 1'b0; bus16.sub = 1'b0; bus16.dataA = '0; bus16.dataB = '0; bus16.outReady = 1'b1;
      bus4.inValid  = 1'b0; bus4.sub  = 1'b0; bus4.dataA  = '0; bus4.dataB  = '0; bus4.outReady  = 1'b1;
      bus8.inValid  = 1'b0; bus8.sub  = 1'b0; bus8.dataA  = '0; bus8.dataB  = '0; bus8.outReady  = 1'b1;
      test_reset();
      test_directed();
      test_back_to_back();
      test_reset_flight();
      test_bubbles();
      test_single_stage();
      test_seg2();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
